// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - Wait-state SRAM responder with four-phase req/ack handshake
// Optional feature macro: SRAM_PARITY_EN (adds per-word even parity, err and inj_perr ports)

module sram_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
`ifdef SRAM_PARITY_EN
  output logic       busy,
  output logic       err,
  input  logic       inj_perr
`else
  output logic       busy
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Counter load value; unused when there are no wait states
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       lat_we;
  logic [4:0] lat_addr;
  logic [7:0] lat_wdata;

`ifdef SRAM_PARITY_EN
  logic [8:0] mem [DEPTH];
  logic       lat_inj;
  logic       err_q;
`else
  logic [7:0] mem [DEPTH];
`endif

  // State and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = ACCESS;
        else             cnt_next   = cnt - 4'd1;
      end
      ACCESS: state_next = ACK;
      ACK: begin
        if (!req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture in IDLE and read data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= 5'd0;
      lat_wdata <= 8'h00;
      rdata     <= 8'h00;
`ifdef SRAM_PARITY_EN
      lat_inj   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
`ifdef SRAM_PARITY_EN
        lat_inj   <= inj_perr;
`endif
      end
      if (state == ACCESS && !lat_we) rdata <= mem[lat_addr][7:0];
`ifdef SRAM_PARITY_EN
      // Odd total parity over the 9 stored bits marks a corrupted word
      if (state == ACCESS)   err_q <= !lat_we && (^mem[lat_addr]);
      else if (state != ACK) err_q <= 1'b0;
`endif
    end
  end

  // Memory array: written only from ACCESS, never cleared by reset
  always_ff @(posedge clk) begin
    if (state == ACCESS && lat_we) begin
`ifdef SRAM_PARITY_EN
      mem[lat_addr] <= {(^lat_wdata) ^ lat_inj, lat_wdata};
`else
      mem[lat_addr] <= lat_wdata;
`endif
    end
  end

  assign ack  = (state == ACK);
  assign busy = (state != IDLE);
`ifdef SRAM_PARITY_EN
  assign err  = err_q && (state == ACK);
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - Directed self-checking bench for sram_responder

module tb_sram_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [4:0] addr = 5'd0;
  logic [7:0] wdata = 8'h00;
  logic       inj_perr = 1'b0;
  logic [7:0] rdata_s, rdata_f;
  logic       ack_s, ack_f, busy_s, busy_f;
  logic       err_s, err_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Slow instance: two wait states
  sram_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_s), .ack(ack_s),
`ifdef SRAM_PARITY_EN
    .busy(busy_s), .err(err_s), .inj_perr(inj_perr)
`else
    .busy(busy_s)
`endif
  );

  // Fast instance: no wait states
  sram_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_f), .ack(ack_f),
`ifdef SRAM_PARITY_EN
    .busy(busy_f), .err(err_f), .inj_perr(inj_perr)
`else
    .busy(busy_f)
`endif
  );

`ifndef SRAM_PARITY_EN
  assign err_s = 1'b0;
  assign err_f = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_s || busy_f) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy_s || busy_f) begin
      errors++;
      $display("FAIL idle_timeout: busy_s=%0b busy_f=%0b required 0", busy_s, busy_f);
    end
  endtask

  // One full handshake observed on the chosen instance; inputs are scrambled after sampling
  task automatic xact(input bit w, input logic [4:0] a, input logic [7:0] d, input bit fast,
                      input int hold, input bit inj, output logic [7:0] rd, output int lat,
                      output logic er);
    int n = 0;
    req = 1'b1; we = w; addr = a; wdata = d; inj_perr = inj;
    step();
    we = ~w; addr = ~a; wdata = ~d; inj_perr = ~inj;
    while (!(fast ? ack_f : ack_s) && n < 20) begin
      checks++;
      if ((fast ? busy_f : busy_s) !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_wait: busy=%0b required 1", fast ? busy_f : busy_s);
      end
      step();
      n++;
    end
    lat = n;
    rd  = fast ? rdata_f : rdata_s;
    er  = fast ? err_f : err_s;
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if ((fast ? ack_f : ack_s) !== 1'b1) begin
        errors++;
        $display("FAIL ack_hold: cycle %0d ack=%0b required 1", i, fast ? ack_f : ack_s);
      end
    end
    req = 1'b0;
    step();
    checks++;
    if ((fast ? ack_f : ack_s) !== 1'b0 || (fast ? busy_f : busy_s) !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: ack=%0b busy=%0b required 0 0",
               fast ? ack_f : ack_s, fast ? busy_f : busy_s);
    end
    wait_idle();
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if (ack_s !== 1'b0 || busy_s !== 1'b0 || rdata_s !== 8'h00 || rdata_f !== 8'h00 ||
        err_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ack=%0b busy=%0b rdata=%h/%h err=%0b required 0 0 00/00 0",
               ack_s, busy_s, rdata_s, rdata_f, err_s);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    logic [7:0] rd; int lat; logic er;
    xact(1'b1, 5'd3, 8'hA5, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("write_latency", 8'(lat), 8'd3);
    xact(1'b0, 5'd3, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("read_latency", 8'(lat), 8'd3);
    chk8("read_a5", rd, 8'hA5);
    xact(1'b1, 5'd3, 8'h3C, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("write_keeps_rdata", rd, 8'hA5);
    xact(1'b0, 5'd3, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("raw_3c", rd, 8'h3C);
  endtask

  task automatic test_zero_wait();
    logic [7:0] rd; int lat; logic er;
    xact(1'b1, 5'd31, 8'h11, 1'b1, 0, 1'b0, rd, lat, er);
    chk8("fast_write_latency", 8'(lat), 8'd1);
    xact(1'b0, 5'd31, 8'h00, 1'b1, 0, 1'b0, rd, lat, er);
    chk8("fast_read_latency", 8'(lat), 8'd1);
    chk8("fast_read_11", rd, 8'h11);
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd; int lat; logic er;
    xact(1'b1, 5'd7, 8'h42, 1'b0, 0, 1'b0, rd, lat, er);
    req = 1'b1; we = 1'b1; addr = 5'd7; wdata = 8'hFF;
    step();
    req = 1'b0;
    chk8("in_wait_busy", {7'd0, busy_s}, 8'd1);
    reset = 1'b1;
    #2;
    chk8("abort_busy", {7'd0, busy_s}, 8'd0);
    chk8("abort_ack", {7'd0, ack_s}, 8'd0);
    chk8("abort_rdata", rdata_s, 8'h00);
    step();
    reset = 1'b0;
    xact(1'b0, 5'd7, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("post_reset_latency", 8'(lat), 8'd3);
    chk8("mem7_kept", rd, 8'h42);
  endtask

  task automatic test_hold();
    logic [7:0] rd; int lat; logic er;
    xact(1'b1, 5'd9, 8'h5A, 1'b0, 5, 1'b0, rd, lat, er);
    xact(1'b0, 5'd9, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("hold_read_5a", rd, 8'h5A);
  endtask

  task automatic test_early_drop();
    logic [7:0] rd; int lat; logic er;
    int n = 0;
    req = 1'b1; we = 1'b1; addr = 5'd12; wdata = 8'h77;
    step();
    req = 1'b0; addr = 5'd0; wdata = 8'h00;
    while (!ack_s && n < 20) begin
      step();
      n++;
    end
    chk8("early_drop_latency", 8'(n), 8'd3);
    step();
    chk8("early_drop_pulse", {6'd0, ack_s, busy_s}, 8'd0);
    wait_idle();
    xact(1'b0, 5'd12, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("early_drop_data", rd, 8'h77);
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity();
    logic [7:0] rd; int lat; logic er;
    xact(1'b1, 5'd20, 8'h0F, 1'b0, 0, 1'b1, rd, lat, er);
    chk8("perr_write_err", {7'd0, er}, 8'd0);
    xact(1'b0, 5'd20, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("perr_read_err", {7'd0, er}, 8'd1);
    chk8("perr_read_data", rd, 8'h0F);
    xact(1'b1, 5'd20, 8'h0F, 1'b0, 0, 1'b0, rd, lat, er);
    xact(1'b0, 5'd20, 8'h00, 1'b0, 0, 1'b0, rd, lat, er);
    chk8("clean_read_err", {7'd0, er}, 8'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_reset_abort();
    test_hold();
    test_early_drop();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of wait-state cycles inserted before each access; legal range 0..15.
REQ-002 Parameter: DEPTH, default 32, number of 8-bit words; fixed to 2**5 and matched to the 5-bit address.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  1  transaction request from the initiator; four-phase handshake.
REQ-006 Port: we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 Port: addr  input  5  word address; sampled with req.
REQ-008 Port: wdata  input  8  write data; sampled with req and ignored on reads.
REQ-009 Port: rdata  output  8  read data; valid while ack=1 after a read.
REQ-010 Port: ack  output  1  transaction complete.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: err  output  1  parity error flag; exists only when SRAM_PARITY_EN is defined.
REQ-013 Port: inj_perr  input  1  inverts the stored parity bit on a write; exists only when SRAM_PARITY_EN is defined.

Function
REQ-014 FSM states: IDLE, WAIT, ACCESS, ACK, registered, with a 4-bit wait counter.
REQ-015 IDLE with req=1 at an edge: latch we, addr and wdata, load the counter with WAIT_CYCLES-1, and go to WAIT; go directly to ACCESS when WAIT_CYCLES=0.
REQ-016 WAIT: decrement the counter each edge and go to ACCESS at the edge where the counter equals 0.
REQ-017 ACCESS, one cycle: a write stores the latched wdata to mem[addr]; a read loads mem[addr] into rdata; then go to ACK.
REQ-018 ACK: ack=1; remain in ACK while req=1; return to IDLE at the first edge with req=0, so ack lasts at least one cycle.
REQ-019 Latency: if req is first sampled high in IDLE at edge k, ack is high immediately after edge k+WAIT_CYCLES+1.
REQ-020 Changes to addr, we or wdata after the sampling edge do not affect the transaction in progress.
REQ-021 If req drops before ack, the transaction still completes; ack pulses for exactly one cycle and the FSM returns to IDLE.
REQ-022 rdata holds the last read value until the next read's ACCESS; writes never change rdata.
REQ-023 Read-after-write to the same address in back-to-back transactions returns the new data.
REQ-024 A new transaction is accepted only from IDLE, so a req held high continuously across ACK produces no second transaction.

Reset
REQ-025 Reset forces state=IDLE, counter=0, ack=0, busy=0, rdata=8'h00, and err=0 where present.
REQ-026 Memory contents are not affected by reset.
REQ-027 Reset asserted before the ACCESS edge of a write leaves mem unchanged (write aborted).
REQ-028 After reset deasserts, a request is accepted at the first edge with req=1.

Configuration
REQ-029 SRAM_PARITY_EN defined: each word stores a 9th even-parity bit computed on write, XORed with inj_perr.
REQ-030 SRAM_PARITY_EN defined: on a read, a parity mismatch sets err=1 for the duration of ack; err=0 otherwise.
REQ-031 SRAM_PARITY_EN undefined: no parity storage, and no err or inj_perr ports.

Verification
REQ-032 WAIT_CYCLES=2: write 8'hA5 to addr 3, sampled at edge k -> ack high after edge k+3; mem[3]=8'hA5; busy high from edge k until ack falls.
REQ-033 Read addr 3 after REQ-032 -> rdata=8'hA5 while ack=1; a following write of 8'h3C to addr 3 leaves rdata=8'hA5.
REQ-034 WAIT_CYCLES=0: write 8'h11 to addr 31, then read addr 31 back-to-back -> each ack after edge k+1; rdata=8'h11.
REQ-035 Write 8'hFF to addr 7 with reset pulsed while in WAIT -> state returns to IDLE, ack=0, and mem[7] keeps its prior value.
REQ-036 Req held high for 5 cycles after ack rises -> ack stays high 5 cycles, and exactly one write occurs.
REQ-037 SRAM_PARITY_EN: write 8'h0F with inj_perr=1, then read it -> err=1 while ack=1; rewrite with inj_perr=0 and read -> err=0.
